multicycle_control: RTL and testbench
=====================================

// Module: multicycle_control
// PURPOSE
//  Moore FSM that sequences the shared multicycle MIPS datapath (one memory, one ALU, IR/MDR/A/B/ALUOut regs).
//  Decodes IR opcode; drives per-state mux/enable controls. Stalls on memory via mem_ready.
//  Supports R-type, ADDI, LW, SW, BEQ, BNE, J. Sits between IR opcode field and datapath/alu_control.
// PARAMETERS
//  SW_EN      1   1: SW (6'h2B) legal; 0: SW decodes as illegal
// PORTS
//  clk          in   1  clock, rising edge
//  rst          in   1  synchronous, active-high reset
//  opcode       in   6  IR[31:26]; stable except when irWrite=1
//  mem_ready    in   1  memory completes read/write this cycle
//  pcWrite      out  1  unconditional PC load
//  pcWriteCond  out  1  PC load if branch condition met
//  branchNe     out  1  1: condition is !zero (BNE); 0: zero (BEQ)
//  pcSource     out  2  00 ALU result, 01 ALUOut, 10 jump target
//  iorD         out  1  mem addr: 0 PC, 1 ALUOut
//  memRead      out  1  memory read strobe
//  memWrite     out  1  memory write strobe
//  irWrite      out  1  IR load
//  regDest      out  1  write reg: 0 rt, 1 rd
//  memToReg     out  1  writeback: 0 ALUOut, 1 MDR
//  regWrite     out  1  register-file write enable
//  aluSrcA      out  1  0 PC, 1 A
//  aluSrcB      out  2  00 B, 01 const 4, 10 signext imm, 11 signext imm<<2
//  aluOp        out  2  00 add, 01 sub, 10 use funct
//  retire       out  1  1-cycle pulse in last state of each instruction
//  illegal_op   out  1  1-cycle pulse in DECODE for unsupported opcode
//  state        out  4  current state (debug)
// BEHAVIOUR
//  - State reg updates on posedge clk; all outputs combinational from state (+opcode, mem_ready where noted).
//  - rst=1 at edge: state<=FETCH(0). While rst=1 every output except state is forced 0.
//  - Outputs not listed for a state are 0. Encodings:
//  FETCH(0):  memRead=1, iorD=0, aluSrcA=0, aluSrcB=01, aluOp=00, pcSource=00,
//             irWrite=pcWrite=mem_ready. mem_ready=0 -> stay; 1 -> DECODE.
//  DECODE(1): aluSrcA=0, aluSrcB=11, aluOp=00 (branch target). Next by opcode:
//             6'h00->EXEC, 6'h08->ADDIEX, 6'h23/6'h2B->MEMADR, 6'h04/6'h05->BRANCH, 6'h02->JUMP,
//             other (or 6'h2B with SW_EN=0)->FETCH with illegal_op=1, retire=0.
//  MEMADR(2): aluSrcA=1, aluSrcB=10, aluOp=00. LW->MEMRD, SW->MEMWR.
//  MEMRD(3):  memRead=1, iorD=1. wait mem_ready -> MEMWB.
//  MEMWB(4):  regWrite=1, regDest=0, memToReg=1, retire=1 -> FETCH.
//  MEMWR(5):  memWrite=1, iorD=1, retire=mem_ready. wait mem_ready -> FETCH.
//  EXEC(6):   aluSrcA=1, aluSrcB=00, aluOp=10 -> RWB.
//  RWB(7):    regWrite=1, regDest=1, memToReg=0, retire=1 -> FETCH.
//  ADDIEX(8): aluSrcA=1, aluSrcB=10, aluOp=00 -> ADDIWB.
//  ADDIWB(9): regWrite=1, regDest=0, memToReg=0, retire=1 -> FETCH.
//  BRANCH(10): aluSrcA=1, aluSrcB=00, aluOp=01, pcWriteCond=1, pcSource=01,
//             branchNe=(opcode==6'h05), retire=1 -> FETCH.
//  JUMP(11):  pcWrite=1, pcSource=10, retire=1 -> FETCH.
//  States 12-15 unreachable; if entered, outputs 0, next=FETCH.
//  - Cycles per instr with mem_ready=1: BEQ/BNE/J 3, R/ADDI/SW 4, LW 5; each memory wait adds 1.
//  - memRead and memWrite never both 1; regWrite never 1 in FETCH/DECODE.
//  - rst mid-instruction aborts it: no retire, no writes after the reset edge.
// TESTING
//  - rst 2 cycles, mem_ready=1: outputs 0 during rst; first cycle after: state=0, memRead=1, pcWrite=1.
//  - R-type 6'h00, mem_ready=1: states 0,1,6,7; aluOp=10 in EXEC; regWrite=regDest=retire=1 in RWB.
//  - LW 6'h23, mem_ready low 2 cycles in MEMRD: 0,1,2,3,3,3,4; memToReg=1 in MEMWB; 7 cycles total.
//  - BNE 6'h05: 0,1,10 with pcWriteCond=1, branchNe=1, aluOp=01; BEQ 6'h04 same with branchNe=0.
//  - J 6'h02 -> pcWrite=1, pcSource=10 in JUMP; opcode 6'h3F -> illegal_op pulse in DECODE, back to 0, no retire.
//  - SW 6'h2B with SW_EN=1: 0,1,2,5, memWrite=1, iorD=1; rst asserted in MEMWR -> state 0, memWrite=0.

Source files
------------

// File: rtl/multicycle_control.sv
// Multicycle MIPS main control: Moore FSM that sequences the shared datapath
// (single memory, single ALU, IR/MDR/A/B/ALUOut) one state per cycle.
// Supports R-type, ADDI, LW, SW, BEQ, BNE and J; waits on memory via mem_ready.
//
// Ports
//   clk, rst            clock (rising edge), synchronous active-high reset
//   opcode[5:0]         IR[31:26], held stable except in the cycle IR loads
//   mem_ready           memory completes the current read/write this cycle
//   pcWrite             unconditional PC load
//   pcWriteCond         PC load gated by branch condition
//   branchNe            branch condition select: 1 !zero (BNE), 0 zero (BEQ)
//   pcSource[1:0]       PC source: 00 ALU result, 01 ALUOut, 10 jump target
//   iorD                memory address: 0 PC, 1 ALUOut
//   memRead, memWrite   memory strobes
//   irWrite             IR load
//   regDest             register write address: 0 rt, 1 rd
//   memToReg            writeback data: 0 ALUOut, 1 MDR
//   regWrite            register-file write enable
//   aluSrcA             ALU A: 0 PC, 1 A
//   aluSrcB[1:0]        ALU B: 00 B, 01 4, 10 signext imm, 11 signext imm<<2
//   aluOp[1:0]          00 add, 01 sub, 10 decode funct
//   retire              one-cycle pulse in the final state of an instruction
//   illegal_op          one-cycle pulse in DECODE for an unsupported opcode
//   state[3:0]          current FSM state (debug)
module multicycle_control #(
  parameter bit SW_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pcWrite,
  output logic       pcWriteCond,
  output logic       branchNe,
  output logic [1:0] pcSource,
  output logic       iorD,
  output logic       memRead,
  output logic       memWrite,
  output logic       irWrite,
  output logic       regDest,
  output logic       memToReg,
  output logic       regWrite,
  output logic       aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [1:0] aluOp,
  output logic       retire,
  output logic       illegal_op,
  output logic [3:0] state
);

  localparam int unsigned STATE_W = 4;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef enum logic [STATE_W-1:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    RWB    = 4'd7,
    ADDIEX = 4'd8,
    ADDIWB = 4'd9,
    BRANCH = 4'd10,
    JUMP   = 4'd11
  } state_t;

  state_t state_q;
  state_t state_d;

  // SW is only a legal store when the build enables it.
  logic sw_legal;
  assign sw_legal = SW_EN && (opcode == OP_SW);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and per-state controls.
  always_comb begin
    state_d     = state_q;
    pcWrite     = 1'b0;
    pcWriteCond = 1'b0;
    branchNe    = 1'b0;
    pcSource    = PCSRC_ALU;
    iorD        = 1'b0;
    memRead     = 1'b0;
    memWrite    = 1'b0;
    irWrite     = 1'b0;
    regDest     = 1'b0;
    memToReg    = 1'b0;
    regWrite    = 1'b0;
    aluSrcA     = 1'b0;
    aluSrcB     = SRCB_B;
    aluOp       = ALUOP_ADD;
    retire      = 1'b0;
    illegal_op  = 1'b0;

    case (state_q)
      FETCH: begin
        // PC+4 computed every fetch cycle; IR and PC commit only when memory delivers.
        memRead  = 1'b1;
        aluSrcB  = SRCB_FOUR;
        pcSource = PCSRC_ALU;
        irWrite  = mem_ready;
        pcWrite  = mem_ready;
        if (mem_ready) begin
          state_d = DECODE;
        end
      end

      DECODE: begin
        // Speculative branch target into ALUOut.
        aluSrcB = SRCB_IMMSH;
        case (opcode)
          OP_RTYPE:      state_d = EXEC;
          OP_ADDI:       state_d = ADDIEX;
          OP_LW:         state_d = MEMADR;
          OP_BEQ,
          OP_BNE:        state_d = BRANCH;
          OP_J:          state_d = JUMP;
          default: begin
            if (sw_legal) begin
              state_d = MEMADR;
            end else begin
              illegal_op = 1'b1;
              state_d    = FETCH;
            end
          end
        endcase
      end

      MEMADR: begin
        aluSrcA = 1'b1;
        aluSrcB = SRCB_IMM;
        if (opcode == OP_LW) begin
          state_d = MEMRD;
        end else if (sw_legal) begin
          state_d = MEMWR;
        end else begin
          state_d = FETCH;
        end
      end

      MEMRD: begin
        memRead = 1'b1;
        iorD    = 1'b1;
        if (mem_ready) begin
          state_d = MEMWB;
        end
      end

      MEMWB: begin
        regWrite = 1'b1;
        memToReg = 1'b1;
        retire   = 1'b1;
        state_d  = FETCH;
      end

      MEMWR: begin
        // The store retires in the cycle memory accepts it.
        memWrite = 1'b1;
        iorD     = 1'b1;
        retire   = mem_ready;
        if (mem_ready) begin
          state_d = FETCH;
        end
      end

      EXEC: begin
        aluSrcA = 1'b1;
        aluSrcB = SRCB_B;
        aluOp   = ALUOP_FUNCT;
        state_d = RWB;
      end

      RWB: begin
        regWrite = 1'b1;
        regDest  = 1'b1;
        retire   = 1'b1;
        state_d  = FETCH;
      end

      ADDIEX: begin
        aluSrcA = 1'b1;
        aluSrcB = SRCB_IMM;
        state_d = ADDIWB;
      end

      ADDIWB: begin
        regWrite = 1'b1;
        retire   = 1'b1;
        state_d  = FETCH;
      end

      BRANCH: begin
        // Subtract A-B for the zero flag; PC takes ALUOut (target from DECODE).
        aluSrcA     = 1'b1;
        aluSrcB     = SRCB_B;
        aluOp       = ALUOP_SUB;
        pcWriteCond = 1'b1;
        pcSource    = PCSRC_ALUOUT;
        branchNe    = (opcode == OP_BNE);
        retire      = 1'b1;
        state_d     = FETCH;
      end

      JUMP: begin
        pcWrite  = 1'b1;
        pcSource = PCSRC_JUMP;
        retire   = 1'b1;
        state_d  = FETCH;
      end

      default: begin
        state_d = FETCH;
      end
    endcase

    // Reset silences every strobe so an aborted instruction cannot write.
    if (rst) begin
      pcWrite     = 1'b0;
      pcWriteCond = 1'b0;
      branchNe    = 1'b0;
      pcSource    = PCSRC_ALU;
      iorD        = 1'b0;
      memRead     = 1'b0;
      memWrite    = 1'b0;
      irWrite     = 1'b0;
      regDest     = 1'b0;
      memToReg    = 1'b0;
      regWrite    = 1'b0;
      aluSrcA     = 1'b0;
      aluSrcB     = SRCB_B;
      aluOp       = ALUOP_ADD;
      retire      = 1'b0;
      illegal_op  = 1'b0;
    end
  end

  assign state = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class through
// its state sequence and checks the key controls in every state.
module tb_multicycle_control;

  logic       clk;
  logic       rst;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pcWrite, pcWriteCond, branchNe, iorD, memRead, memWrite, irWrite;
  logic       regDest, memToReg, regWrite, aluSrcA, retire, illegal_op;
  logic [1:0] pcSource, aluSrcB, aluOp;
  logic [3:0] state;
  logic [18:0] all_out;

  int errors = 0;
  int checks = 0;

  multicycle_control #(.SW_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .branchNe(branchNe),
    .pcSource(pcSource), .iorD(iorD), .memRead(memRead), .memWrite(memWrite),
    .irWrite(irWrite), .regDest(regDest), .memToReg(memToReg),
    .regWrite(regWrite), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .aluOp(aluOp),
    .retire(retire), .illegal_op(illegal_op), .state(state)
  );

  assign all_out = {pcWrite, pcWriteCond, branchNe, pcSource, iorD, memRead,
                    memWrite, irWrite, regDest, memToReg, regWrite, aluSrcA,
                    aluSrcB, aluOp, retire, illegal_op};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic test_reset();
    rst = 1'b1; mem_ready = 1'b1; opcode = 6'h00;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      checks++; if (all_out !== 19'h0) begin errors++; $display("FAIL reset_outs cyc%0d: got %h want 0", i, all_out); end
      checks++; if (state !== 4'd0) begin errors++; $display("FAIL reset_state cyc%0d: got %0d want 0", i, state); end
    end
    rst = 1'b0; #1;
    checks++; if (state !== 4'd0) begin errors++; $display("FAIL post_reset_state: got %0d want 0", state); end
    checks++; if (memRead !== 1'b1 || pcWrite !== 1'b1 || irWrite !== 1'b1)
      begin errors++; $display("FAIL post_reset_fetch: memRead=%b pcWrite=%b irWrite=%b want 1 1 1", memRead, pcWrite, irWrite); end
    mem_ready = 1'b0; #1;
    checks++; if (memRead !== 1'b1 || pcWrite !== 1'b0 || irWrite !== 1'b0)
      begin errors++; $display("FAIL fetch_stall: memRead=%b pcWrite=%b irWrite=%b want 1 0 0", memRead, pcWrite, irWrite); end
    @(negedge clk); #1;
    checks++; if (state !== 4'd0) begin errors++; $display("FAIL fetch_hold: got %0d want 0", state); end
  endtask

  task automatic test_rtype();
    logic [3:0] exp_st [0:3];
    exp_st = '{4'd0, 4'd1, 4'd6, 4'd7};
    opcode = 6'h00; mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (state !== exp_st[i]) begin errors++; $display("FAIL rtype_state[%0d]: got %0d want %0d", i, state, exp_st[i]); end
      if (i == 1) begin
        checks++; if (aluSrcA !== 1'b0 || aluSrcB !== 2'b11 || aluOp !== 2'b00 || regWrite !== 1'b0)
          begin errors++; $display("FAIL decode_ctl: srcA=%b srcB=%b op=%b rw=%b want 0 11 00 0", aluSrcA, aluSrcB, aluOp, regWrite); end
      end
      if (i == 2) begin
        checks++; if (aluOp !== 2'b10 || aluSrcA !== 1'b1 || aluSrcB !== 2'b00 || retire !== 1'b0)
          begin errors++; $display("FAIL exec_ctl: op=%b srcA=%b srcB=%b ret=%b want 10 1 00 0", aluOp, aluSrcA, aluSrcB, retire); end
      end
      if (i == 3) begin
        checks++; if (regWrite !== 1'b1 || regDest !== 1'b1 || retire !== 1'b1 || memToReg !== 1'b0)
          begin errors++; $display("FAIL rwb_ctl: rw=%b rd=%b ret=%b m2r=%b want 1 1 1 0", regWrite, regDest, retire, memToReg); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_lw();
    logic [3:0] exp_st [0:6];
    logic       mr [0:6];
    exp_st = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd4};
    mr     = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    opcode = 6'h23;
    for (int i = 0; i < 7; i++) begin
      mem_ready = mr[i]; #1;
      checks++; if (state !== exp_st[i]) begin errors++; $display("FAIL lw_state[%0d]: got %0d want %0d", i, state, exp_st[i]); end
      checks++; if ((memRead & memWrite) !== 1'b0) begin errors++; $display("FAIL lw_rd_wr_excl[%0d]: rd=%b wr=%b", i, memRead, memWrite); end
      if (i == 2) begin
        checks++; if (aluSrcA !== 1'b1 || aluSrcB !== 2'b10 || aluOp !== 2'b00)
          begin errors++; $display("FAIL memadr_ctl: srcA=%b srcB=%b op=%b want 1 10 00", aluSrcA, aluSrcB, aluOp); end
      end
      if (i == 3) begin
        checks++; if (memRead !== 1'b1 || iorD !== 1'b1 || retire !== 1'b0)
          begin errors++; $display("FAIL memrd_ctl: rd=%b iorD=%b ret=%b want 1 1 0", memRead, iorD, retire); end
      end
      if (i == 6) begin
        checks++; if (memToReg !== 1'b1 || regWrite !== 1'b1 || regDest !== 1'b0 || retire !== 1'b1)
          begin errors++; $display("FAIL memwb_ctl: m2r=%b rw=%b rd=%b ret=%b want 1 1 0 1", memToReg, regWrite, regDest, retire); end
      end
      @(negedge clk);
    end
    #1;
    checks++; if (state !== 4'd0) begin errors++; $display("FAIL lw_done: got %0d want 0 after 7 cycles", state); end
  endtask

  task automatic test_branch();
    logic [5:0] ops [0:1];
    ops = '{6'h05, 6'h04};
    mem_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      opcode = ops[k];
      for (int i = 0; i < 3; i++) begin
        #1;
        checks++; if (state !== 4'(i == 2 ? 10 : i)) begin errors++; $display("FAIL br%0h_state[%0d]: got %0d want %0d", ops[k], i, state, (i == 2 ? 10 : i)); end
        if (i == 2) begin
          checks++; if (pcWriteCond !== 1'b1 || aluOp !== 2'b01 || pcSource !== 2'b01 || retire !== 1'b1 || pcWrite !== 1'b0)
            begin errors++; $display("FAIL br%0h_ctl: pwc=%b op=%b src=%b ret=%b pw=%b want 1 01 01 1 0", ops[k], pcWriteCond, aluOp, pcSource, retire, pcWrite); end
          checks++; if (branchNe !== (k == 0))
            begin errors++; $display("FAIL br%0h_ne: got %b want %b", ops[k], branchNe, (k == 0)); end
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_jump();
    opcode = 6'h02; mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (state !== 4'(i == 2 ? 11 : i)) begin errors++; $display("FAIL j_state[%0d]: got %0d want %0d", i, state, (i == 2 ? 11 : i)); end
      if (i == 2) begin
        checks++; if (pcWrite !== 1'b1 || pcSource !== 2'b10 || retire !== 1'b1)
          begin errors++; $display("FAIL jump_ctl: pw=%b src=%b ret=%b want 1 10 1", pcWrite, pcSource, retire); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_illegal();
    opcode = 6'h3F; mem_ready = 1'b1;
    @(negedge clk); #1;
    checks++; if (state !== 4'd1 || illegal_op !== 1'b1 || retire !== 1'b0)
      begin errors++; $display("FAIL illegal_decode: st=%0d ill=%b ret=%b want 1 1 0", state, illegal_op, retire); end
    @(negedge clk); #1;
    checks++; if (state !== 4'd0 || illegal_op !== 1'b0)
      begin errors++; $display("FAIL illegal_return: st=%0d ill=%b want 0 0", state, illegal_op); end
  endtask

  task automatic test_addi_stall();
    logic [3:0] exp_st [0:4];
    logic       mr [0:4];
    exp_st = '{4'd0, 4'd0, 4'd1, 4'd8, 4'd9};
    mr     = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    opcode = 6'h08;
    for (int i = 0; i < 5; i++) begin
      mem_ready = mr[i]; #1;
      checks++; if (state !== exp_st[i]) begin errors++; $display("FAIL addi_state[%0d]: got %0d want %0d", i, state, exp_st[i]); end
      if (i == 3) begin
        checks++; if (aluSrcA !== 1'b1 || aluSrcB !== 2'b10 || aluOp !== 2'b00)
          begin errors++; $display("FAIL addiex_ctl: srcA=%b srcB=%b op=%b want 1 10 00", aluSrcA, aluSrcB, aluOp); end
      end
      if (i == 4) begin
        checks++; if (regWrite !== 1'b1 || regDest !== 1'b0 || memToReg !== 1'b0 || retire !== 1'b1)
          begin errors++; $display("FAIL addiwb_ctl: rw=%b rd=%b m2r=%b ret=%b want 1 0 0 1", regWrite, regDest, memToReg, retire); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_sw();
    logic [3:0] exp_st [0:3];
    exp_st = '{4'd0, 4'd1, 4'd2, 4'd5};
    opcode = 6'h2B; mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (state !== exp_st[i]) begin errors++; $display("FAIL sw_state[%0d]: got %0d want %0d", i, state, exp_st[i]); end
      if (i == 3) begin
        checks++; if (memWrite !== 1'b1 || iorD !== 1'b1 || memRead !== 1'b0 || retire !== 1'b1)
          begin errors++; $display("FAIL memwr_ctl: wr=%b iorD=%b rd=%b ret=%b want 1 1 0 1", memWrite, iorD, memRead, retire); end
      end
      @(negedge clk);
    end
    #1;
    checks++; if (state !== 4'd0) begin errors++; $display("FAIL sw_done: got %0d want 0", state); end
  endtask

  task automatic test_sw_reset();
    opcode = 6'h2B; mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    mem_ready = 1'b0; #1;
    checks++; if (state !== 4'd5 || memWrite !== 1'b1 || retire !== 1'b0)
      begin errors++; $display("FAIL memwr_wait: st=%0d wr=%b ret=%b want 5 1 0", state, memWrite, retire); end
    @(negedge clk); #1;
    checks++; if (state !== 4'd5) begin errors++; $display("FAIL memwr_hold: got %0d want 5", state); end
    rst = 1'b1; #1;
    checks++; if (memWrite !== 1'b0 || iorD !== 1'b0 || retire !== 1'b0)
      begin errors++; $display("FAIL rst_force: wr=%b iorD=%b ret=%b want 0 0 0", memWrite, iorD, retire); end
    @(negedge clk); #1;
    checks++; if (state !== 4'd0 || memWrite !== 1'b0 || regWrite !== 1'b0 || retire !== 1'b0)
      begin errors++; $display("FAIL rst_abort: st=%0d wr=%b rw=%b ret=%b want 0 0 0 0", state, memWrite, regWrite, retire); end
    rst = 1'b0;
    @(negedge clk); #1;
    checks++; if (state !== 4'd0 || memWrite !== 1'b0)
      begin errors++; $display("FAIL rst_recover: st=%0d wr=%b want 0 0", state, memWrite); end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw();
    test_branch();
    test_jump();
    test_illegal();
    test_addi_stall();
    test_sw();
    test_sw_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
